// File: rtl/arb_pkg.sv
// Shared types, width helpers and the reference round-robin pick for the grant arbiter.
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_e;

  localparam int unsigned N_REQ_DEF    = 4;
  localparam int unsigned MAX_HOLD_DEF = 8;
  localparam int unsigned IDX_W_DEF    = (N_REQ_DEF > 1) ? $clog2(N_REQ_DEF) : 1;
  localparam int unsigned HOLD_W_DEF   = (MAX_HOLD_DEF > 0) ? $clog2(MAX_HOLD_DEF + 1) : 1;

  // One-hot of the first set bit of req searching upward from start, with wrap.
  function automatic logic [N_REQ_DEF-1:0] rr_pick(input logic [N_REQ_DEF-1:0] req,
                                                   input logic [IDX_W_DEF-1:0] start);
    logic [N_REQ_DEF-1:0] res;
    int unsigned          pos;
    res = '0;
    for (int unsigned k = 0; k < N_REQ_DEF; k++) begin
      pos = int'(start) + k;
      if (pos >= N_REQ_DEF) pos = pos - N_REQ_DEF;
      if (res == '0 && req[pos]) res[pos] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate / find-first-set / un-rotate: first set req bit at or above start, with wrap.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDX_W-1:0] k;
  logic [IDX_W:0]   sum;

  always_comb begin
    dbl = {req, req};
    rot = dbl[start +: N];
    k   = '0;
    // Scan from the top so the lowest set rotated bit wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) k = IDX_W'(i);
    end
    sum = {1'b0, start} + {1'b0, k};
    if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
    idx    = sum[IDX_W-1:0];
    any    = |req;
    onehot = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with bounded hold: registered one-hot grant, valid flag and owner index.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int unsigned HOLD_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0]  gnt_d;
  logic [IDX_W-1:0]  idx_d;

  logic [N_REQ-1:0]  pick_req, pick_onehot;
  logic [IDX_W-1:0]  pick_start, pick_idx;
  logic              pick_any;
  logic [IDX_W-1:0]  next_idx;
  logic              owner_req, limit_hit;
  logic [HOLD_W-1:0] hold_inc;

  rr_priority_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (pick_req),
    .start  (pick_start),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign next_idx  = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
  assign owner_req = |(req & gnt);
  assign limit_hit = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD));
  assign hold_inc  = (hold_q == '1) ? hold_q : hold_q + HOLD_W'(1);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    gnt_d      = gnt;
    idx_d      = gnt_idx;
    pick_req   = req;
    pick_start = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_onehot;
          idx_d   = pick_idx;
          hold_d  = HOLD_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        // The owner never competes in its own hand-over search.
        pick_req   = req & ~gnt;
        pick_start = next_idx;
        if (!owner_req) begin
          ptr_d = next_idx;
          if (pick_any) begin
            gnt_d  = pick_onehot;
            idx_d  = pick_idx;
            hold_d = HOLD_W'(1);
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if (limit_hit && pick_any) begin
          ptr_d  = next_idx;
          gnt_d  = pick_onehot;
          idx_d  = pick_idx;
          hold_d = HOLD_W'(1);
        end else if (limit_hit) begin
          hold_d = HOLD_W'(1);
        end else begin
          hold_d = hold_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_idx <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt     <= gnt_d;
      gnt_vld <= |gnt_d;
      gnt_idx <= idx_d;
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed plus randomized check of rr_grant_arbiter against a cycle-level behavioural model.
module tb_rr_grant_arbiter;
  import arb_pkg::*;

  localparam int N  = 4;
  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic [1:0] gnt_idx;

  int compared = 0;
  int mismatched = 0;

  // Model state: owner (-1 = idle), search pointer, cycles held, last owner index.
  int owner, mptr, held, midx;

  rr_grant_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always #5 clk = ~clk;

  function automatic int search(input logic [3:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r_rst, input logic [3:0] r);
    logic [3:0] others;
    if (r_rst) begin
      owner = -1; mptr = 0; held = 0; midx = 0;
    end else if (owner < 0) begin
      if (r != 0) begin
        owner = search(r, mptr); held = 1; midx = owner;
      end
    end else begin
      others = r;
      others[owner] = 1'b0;
      if (!r[owner]) begin
        mptr = (owner + 1) % N;
        if (others != 0) begin
          owner = search(others, mptr); held = 1; midx = owner;
        end else begin
          owner = -1;
        end
      end else if (MH != 0 && held >= MH && others != 0) begin
        mptr = (owner + 1) % N;
        owner = search(others, mptr); held = 1; midx = owner;
      end else if (MH != 0 && held >= MH) begin
        held = 1;
      end else begin
        held = held + 1;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [3:0] eg;
    eg = (owner < 0) ? 4'b0000 : 4'(1 << owner);
    compared += 3;
    assert (gnt === eg) else begin
      mismatched++;
      $error("FAIL %s gnt observed=%b expected=%b at %0t", tag, gnt, eg, $time);
    end
    assert (gnt_vld === (owner >= 0)) else begin
      mismatched++;
      $error("FAIL %s gnt_vld observed=%b expected=%b at %0t", tag, gnt_vld, owner >= 0, $time);
    end
    assert (gnt_idx === 2'(midx)) else begin
      mismatched++;
      $error("FAIL %s gnt_idx observed=%0d expected=%0d at %0t", tag, gnt_idx, midx, $time);
    end
  endtask

  // One clock: model consumes the inputs present at the edge, outputs checked 1ns later.
  task automatic step(input string tag);
    @(posedge clk);
    model_step(rst, req);
    #1;
    check(tag);
  endtask

  task automatic expect_gnt(input string tag, input logic [3:0] exp);
    compared++;
    assert (gnt === exp) else begin
      mismatched++;
      $error("FAIL %s gnt observed=%b expected=%b at %0t", tag, gnt, exp, $time);
    end
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] pk;
    owner = -1; mptr = 0; held = 0; midx = 0;
    rst = 1'b1; req = 4'b0000;
    #1;
    step("reset");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("idle_no_req");

    req = 4'b0100;
    step("single_req");
    expect_gnt("single_req_latency", 4'b0100);
    step("single_hold");
    step("single_hold");
    req = 4'b0000;
    step("single_release");
    expect_gnt("single_release_zero", 4'b0000);

    req = 4'b1111;
    step("all_first");
    expect_gnt("all_first_from_ptr3", 4'b1000);
    for (int i = 0; i < 8 * 5; i++) step("all_rotate");

    rst = 1'b1; step("reset2");
    rst = 1'b0; req = 4'b0010;
    step("own1");
    req = 4'b1001;
    step("release_handover");
    expect_gnt("handover_no_bubble", 4'b1000);

    rst = 1'b1; step("reset3");
    rst = 1'b0; req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      step("sole_owner");
      expect_gnt("sole_no_dropout", 4'b0001);
    end

    rst = 1'b1; step("reset4");
    rst = 1'b0; req = 4'b0010;
    step("pre_rst_grant");
    step("pre_rst_hold");
    rst = 1'b1;
    step("mid_grant_reset");
    expect_gnt("mid_reset_drop", 4'b0000);
    rst = 1'b0; req = 4'b0011;
    step("post_reset_ptr0");
    expect_gnt("post_reset_owner0", 4'b0001);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = 4'($urandom_range(0, 15));
        req = r;
        pk = rr_pick(r, 2'(mptr));
        compared++;
        assert (pk === ((r == 0) ? 4'b0000 : 4'(1 << search(r, mptr)))) else begin
          mismatched++;
          $error("FAIL rr_pick observed=%b req=%b start=%0d", pk, r, mptr);
        end
      end
      rst = ($urandom_range(0, 63) == 0);
      step("random");
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
